// File: rtl/posit_mac_pkg.sv
// posit_mac_pkg: shared types and constants for the posit MAC sequencer.
//   state_e    - sequencer FSM states
//   DrainDepth - cycles between the last MAC_EN and the quire holding the final sum
//   ReadDepth  - cycles the MAC needs to present a rounded result on OUT
package posit_mac_pkg;

  localparam int unsigned DrainDepth = 2;
  localparam int unsigned ReadDepth  = 1;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StBias,
    StStream,
    StDrain1,
    StDrain2,
    StRead,
    StHold
  } state_e;

endpackage

// File: rtl/posit_mac_seq_if.sv
// posit_mac_seq_if: operand stream, MAC control and result port of the posit MAC sequencer.
//   a_valid/a_ready/a_data/b_data       - operand-pair stream into the sequencer
//   mac_in1/mac_in2/mac_bias            - operand and bias posits toward the MAC
//   mac_en/purge/bias_en/result_req_pls - MAC control pulses
//   mac_out                             - rounded posit from the MAC
//   res_valid/res_ready/res_data        - result handshake out of the sequencer
// master: the sequencer side. slave: the environment (source, MAC and result sink).
interface posit_mac_seq_if #(
  parameter int unsigned N = 8
) ();

  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] a_data;
  logic [N-1:0] b_data;

  logic [N-1:0] mac_in1;
  logic [N-1:0] mac_in2;
  logic [N-1:0] mac_bias;
  logic         mac_en;
  logic         purge;
  logic         bias_en;
  logic         result_req_pls;
  logic [N-1:0] mac_out;

  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;

  modport master (
    input  a_valid, a_data, b_data, mac_out, res_ready,
    output a_ready, mac_in1, mac_in2, mac_bias, mac_en, purge, bias_en, result_req_pls,
    output res_valid, res_data
  );

  modport slave (
    output a_valid, a_data, b_data, mac_out, res_ready,
    input  a_ready, mac_in1, mac_in2, mac_bias, mac_en, purge, bias_en, result_req_pls,
    input  res_valid, res_data
  );

endinterface

// File: rtl/posit_mac_seq.sv
// posit_mac_seq: drives one posit MAC/quire unit through a full dot product.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin a dot product (accepted only in idle)
//   vec_len     - number of operand pairs, latched with start
//   use_bias    - preload bias_in into the quire before the products, latched with start
//   bias_in     - bias posit, latched with start
//   abort       - return to idle and purge the quire
//   busy        - high whenever not idle
//   bus         - operand stream, MAC control and result handshake
module posit_mac_seq
  import posit_mac_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned Ext = 13
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [Ext-1:0] vec_len,
  input  logic           use_bias,
  input  logic [N-1:0]   bias_in,
  input  logic           abort,
  output logic           busy,
  posit_mac_seq_if.master bus
);

  localparam logic [Ext-1:0] CountOne = Ext'(1);

  state_e         state_q, state_d;
  logic [Ext-1:0] count_q, count_d;
  logic           use_bias_q, use_bias_d;
  logic [N-1:0]   bias_q, bias_d;
  logic [N-1:0]   in1_q, in1_d;
  logic [N-1:0]   in2_q, in2_d;
  logic           mac_en_q, mac_en_d;
  logic           purge_q, purge_d;
  logic           bias_en_q, bias_en_d;
  logic           req_q, req_d;
  logic           res_valid_q, res_valid_d;
  logic [N-1:0]   res_data_q, res_data_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    use_bias_d = use_bias_q;
    bias_d     = bias_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    mac_en_d   = 1'b0;
    res_data_d = res_data_q;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          count_d    = vec_len;
          use_bias_d = use_bias;
          bias_d     = bias_in;
          state_d    = StClr;
        end
      end
      StClr: begin
        if (use_bias_q)            state_d = StBias;
        else if (count_q != '0)    state_d = StStream;
        else                       state_d = StDrain1;
      end
      StBias: begin
        state_d = (count_q != '0) ? StStream : StDrain1;
      end
      StStream: begin
        // a_ready is high for the whole state, so a_valid alone is the handshake.
        if (bus.a_valid) begin
          in1_d    = bus.a_data;
          in2_d    = bus.b_data;
          mac_en_d = 1'b1;
          count_d  = count_q - CountOne;
          if (count_q == CountOne) state_d = StDrain1;
        end
      end
      StDrain1: state_d = StDrain2;
      StDrain2: state_d = StRead;
      StRead: begin
        res_data_d = bus.mac_out;
        state_d    = StHold;
      end
      StHold: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      mac_en_d   = 1'b0;
      res_data_d = '0;
    end

    // Control pulses are registered so they line up with the state they belong to.
    // An abort purges even from idle; the quire is cleared again on the next start anyway.
    purge_d     = abort || (state_d == StClr);
    bias_en_d   = (state_d == StBias);
    req_d       = (state_d == StRead);
    res_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      use_bias_q  <= 1'b0;
      bias_q      <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      mac_en_q    <= 1'b0;
      purge_q     <= 1'b0;
      bias_en_q   <= 1'b0;
      req_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      use_bias_q  <= use_bias_d;
      bias_q      <= bias_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      mac_en_q    <= mac_en_d;
      purge_q     <= purge_d;
      bias_en_q   <= bias_en_d;
      req_q       <= req_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy               = (state_q != StIdle);
  assign bus.a_ready        = (state_q == StStream);
  assign bus.mac_in1        = in1_q;
  assign bus.mac_in2        = in2_q;
  assign bus.mac_bias       = bias_q;
  assign bus.mac_en         = mac_en_q;
  assign bus.purge          = purge_q;
  assign bus.bias_en        = bias_en_q;
  assign bus.result_req_pls = req_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_data       = res_data_q;

endmodule
